interrupt_controller: RTL
=========================

// Module: interrupt_controller
// PURPOSE
//  Prioritises, masks and sequences the 8 interrupt lines (timer, I/O manager) into the single-cycle CPU.
//  - Sits between the interrupt sources and the CPU inside cpu_environment.
//  - Latches requests and picks one by priority.
//  - Drives one request/acknowledge handshake, then holds the CPU in service until end-of-interrupt.
// PARAMETERS
//  N_IRQ      8        number of interrupt lines (1..16)
//  IDX_W      3        width of vector index, = clog2(N_IRQ)
//  ADDR_W     10       width of handler address
//  VEC_BASE   10'h3F0  handler address of line 0
//  EDGE_MASK  8'hFF    per line: 1 = rising-edge triggered, 0 = level triggered
//  MASK_RST   8'hFF    mask reset value (1 = enabled)
//  PRIO_MODE  0        0 = fixed (line 0 highest), 1 = rotating
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       asynchronous, active-low reset
//  irq_in      in   N_IRQ   raw interrupt lines, may be asynchronous
//  mask_we     in   1       write enable for mask register
//  mask_wdata  in   N_IRQ   new mask value
//  mask_q      out  N_IRQ   current mask
//  pending_q   out  N_IRQ   pending bits (before mask)
//  int_req     out  1       interrupt request to CPU
//  int_ack     in   1       CPU accepts request (sampled only in REQ)
//  int_idx     out  IDX_W   granted line index
//  int_addr    out  ADDR_W  handler address = VEC_BASE + int_idx, modulo 2^ADDR_W
//  in_service  out  1       handler running
//  eoi         in   1       end of interrupt (sampled only in SVC)
// BEHAVIOUR
//  Reset (reset=0, immediate)
//   - state=IDLE; int_req, in_service, int_idx, int_addr, pending_q, sync flops = 0; mask_q = MASK_RST.
//   - Mid-handshake reset drops int_req at once; all pending requests are lost.
//  Input path
//   - 2-flop synchroniser per line, then edge detect (sync2 & ~sync2_d).
//   - Edge line: pending set on a detected rise; cleared only by ack of that line. Set wins over clear in the same cycle.
//   - Level line: pending_q = sync2 level (not latched).
//   - Latency: irq_in high before edge E1 -> pending_q=1 after E3 -> int_req=1 after E4 (idle, enabled).
//  Mask
//   - mask_q <= mask_wdata on mask_we; effective next cycle.
//   - Masked edge lines still latch pending. eligible = pending_q & mask_q.
//  FSM IDLE -> REQ -> SVC
//   - IDLE: if eligible != 0, register winner into int_idx/int_addr, int_req<=1, go REQ.
//   - REQ: int_idx/int_addr/int_req stable regardless of mask or pending changes. On int_ack: clear the winner's pending (edge line), int_req<=0, in_service<=1, go SVC.
//   - SVC: on eoi: in_service<=0, go IDLE. The next request can assert the cycle after IDLE is re-entered, never back-to-back with eoi.
//   - int_ack outside REQ and eoi outside SVC are ignored.
//  Priority
//   - PRIO_MODE=0: lowest eligible index wins.
//   - PRIO_MODE=1: pointer reset 0; search starts at pointer; on ack, pointer <= (int_idx+1) mod N_IRQ (wrap).
// STRUCTURE
//  - Shared include cpu_defs.vh: FSM encodings IC_IDLE=2'd0, IC_REQ=2'd1, IC_SVC=2'd2; N_IRQ default.
//  - Sub-module irq_sync_edge (2-flop sync + edge pulse, async active-low reset), generated N_IRQ times.
//  - Priority search is a function inside interrupt_controller.
// TESTING
//  1. Reset, then irq_in[3] pulse 1 cycle (mask FF) -> int_req=1, int_idx=3, int_addr=10'h3F3, 4 edges after the first sampling edge.
//  2. irq_in[5] and [2] rise together, fixed mode -> idx 2 served; after ack+eoi, idx 5 requested next.
//  3. mask=8'hF7, pulse irq_in[3] -> no int_req, pending_q[3]=1; write mask FF -> int_req with idx 3.
//  4. PRIO_MODE=1, lines 0,1,7 pending; serve 0 -> next 1 -> next 7 -> pointer wraps to 0.
//  5. Edge on line 4 in the same cycle as its ack -> pending_q[4] stays 1; after eoi, idx 4 re-requested.
//  6. Assert reset while in REQ and while in SVC -> int_req/in_service 0 immediately, pending_q=0, state IDLE.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM state encoding and default line count.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_SVC  = 2'd2
    } ic_state_t;

    localparam int unsigned IC_N_IRQ = 8;

endpackage

// File: rtl/interrupt_controller_irq_sync_edge.sv
// Two-flop synchroniser for one raw interrupt line plus a one-cycle rising-edge pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_irq,
    output logic o_level,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s2_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= i_irq;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_s2_d;

endmodule

// File: rtl/interrupt_controller.sv
// Latches, masks and prioritises interrupt lines, then runs one req/ack handshake
// and holds the CPU in service until end-of-interrupt.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int unsigned             N_IRQ     = IC_N_IRQ,
    parameter int unsigned             IDX_W     = $clog2(N_IRQ),
    parameter int unsigned             ADDR_W    = 10,
    parameter logic [ADDR_W-1:0]       VEC_BASE  = 10'h3F0,
    parameter logic [N_IRQ-1:0]        EDGE_MASK = 8'hFF,
    parameter logic [N_IRQ-1:0]        MASK_RST  = 8'hFF,
    parameter int unsigned             PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq_in,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_wdata,
    output logic [N_IRQ-1:0]  mask_q,
    output logic [N_IRQ-1:0]  pending_q,
    output logic              int_req,
    input  logic              int_ack,
    output logic [IDX_W-1:0]  int_idx,
    output logic [ADDR_W-1:0] int_addr,
    output logic              in_service,
    input  logic              eoi
);

    ic_state_t          r_state;
    ic_state_t          w_next;
    logic [N_IRQ-1:0]   w_level;
    logic [N_IRQ-1:0]   w_rise;
    logic [N_IRQ-1:0]   r_pend;
    logic [N_IRQ-1:0]   w_clr;
    logic [N_IRQ-1:0]   w_pending;
    logic [N_IRQ-1:0]   w_elig;
    logic [N_IRQ-1:0]   r_mask;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_win;
    logic [ADDR_W-1:0]  r_addr;
    logic               w_take;
    logic               w_ack;

    // Circular search from start; iterating from the farthest offset down lets the nearest eligible line win.
    function automatic logic [IDX_W-1:0] prio_pick(input logic [N_IRQ-1:0] elig,
                                                   input logic [IDX_W-1:0] start);
        int unsigned      pos;
        logic [IDX_W-1:0] p;
        prio_pick = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            pos = (32'(start) + (N_IRQ - 1 - k)) % N_IRQ;
            p   = IDX_W'(pos);
            if (elig[p]) prio_pick = p;
        end
    endfunction

    for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk     (clk),
            .reset   (reset),
            .i_irq   (irq_in[g]),
            .o_level (w_level[g]),
            .o_rise  (w_rise[g])
        );
    end

    assign w_pending = (r_pend & EDGE_MASK) | (w_level & ~EDGE_MASK);
    assign w_elig    = w_pending & r_mask;
    assign w_start   = (PRIO_MODE == 1) ? r_ptr : '0;
    assign w_win     = prio_pick(w_elig, w_start);
    assign w_take    = (r_state == IC_IDLE) && (w_elig != '0);
    assign w_ack     = (r_state == IC_REQ) && int_ack;

    always_comb begin
        w_clr = '0;
        if (w_ack) w_clr[r_idx] = 1'b1;
    end

    // A rise in the same cycle as the ack re-arms the line: set has priority over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (w_rise | (r_pend & ~w_clr)) & EDGE_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IC_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IC_IDLE: if (w_elig != '0) w_next = IC_REQ;
            IC_REQ:  if (int_ack)      w_next = IC_SVC;
            IC_SVC:  if (eoi)          w_next = IC_IDLE;
            default:                   w_next = IC_IDLE;
        endcase
    end

    always_comb begin
        int_req    = (r_state == IC_REQ);
        in_service = (r_state == IC_SVC);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx  <= '0;
            r_addr <= '0;
            r_ptr  <= '0;
            r_mask <= MASK_RST;
        end else begin
            if (w_take) begin
                r_idx  <= w_win;
                r_addr <= VEC_BASE + ADDR_W'(w_win);
            end
            if (w_ack && (PRIO_MODE == 1)) begin
                r_ptr <= IDX_W'((32'(r_idx) + 1) % N_IRQ);
            end
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
        end
    end

    assign mask_q    = r_mask;
    assign pending_q = w_pending;
    assign int_idx   = r_idx;
    assign int_addr  = r_addr;

endmodule
